// File: rtl/pic_inta_sequencer.sv
// 8259A INTA sequencer: drives INT, runs the two-pulse 8086 INTA cycle, owns ISR and EOI/AEOI clearing.
// Optional PIC_INTA_SYNC_EN: passes inta_n through a 2-flop synchronizer before edge detection.
module pic_inta_sequencer #(
  parameter logic [2:0] SPURIOUS_IDX = 3'd7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       int_request,
  input  logic [2:0] serviced_index,
  input  logic [2:0] zero_level_priority,
  input  logic       inta_n,
  input  logic [4:0] vector_base,
  input  logic       aeoi_en,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  output logic       int_out,
  output logic       freezing,
  output logic       int_request_ack,
  output logic       irr_clear,
  output logic [2:0] irr_clear_index,
  output logic [7:0] isr_reg,
  output logic [2:0] reseted_isr_index,
  output logic [7:0] data_out,
  output logic       data_out_en
);

  typedef enum logic [2:0] {IDLE, PENDING, ACK1, WAIT2, ACK2} state_t;

  state_t     state, state_next;
  logic       inta_s, inta_prev;
  logic       inta_fall, inta_rise;
  logic [2:0] idx, idx_next;
  logic       spurious, spurious_next;
  logic       int_out_next, freezing_next, ack_next, irr_clear_next, den_next;
  logic [2:0] irr_clear_index_next, reseted_next;
  logic [7:0] data_out_next, isr_set, isr_clr, isr_next;
  logic       ns_found;
  logic [2:0] ns_index, ns_cand;

`ifdef PIC_INTA_SYNC_EN
  logic [1:0] inta_sync;

  always_ff @(posedge clk) begin
    if (!reset_n) inta_sync <= 2'b11;
    else          inta_sync <= {inta_sync[0], inta_n};
  end

  assign inta_s = inta_sync[1];
`else
  assign inta_s = inta_n;
`endif

  assign inta_fall = inta_prev & ~inta_s;
  assign inta_rise = ~inta_prev & inta_s;

  // Non-specific EOI target: first set ISR bit walking up from the rotation base.
  always_comb begin
    ns_found = 1'b0;
    ns_index = '0;
    ns_cand  = '0;
    for (int k = 0; k < 8; k++) begin
      ns_cand = zero_level_priority + 3'(k);
      if (!ns_found && isr_reg[ns_cand]) begin
        ns_found = 1'b1;
        ns_index = ns_cand;
      end
    end
  end

  always_comb begin
    state_next           = state;
    idx_next             = idx;
    spurious_next        = spurious;
    int_out_next         = int_out;
    freezing_next        = freezing;
    ack_next             = 1'b0;
    irr_clear_next       = 1'b0;
    irr_clear_index_next = irr_clear_index;
    data_out_next        = data_out;
    den_next             = data_out_en;
    reseted_next         = reseted_isr_index;
    isr_set              = '0;
    isr_clr              = '0;

    if (eoi_valid) begin
      if (eoi_specific) begin
        isr_clr[eoi_level] = 1'b1;
        reseted_next       = eoi_level;
      end else if (ns_found) begin
        isr_clr[ns_index] = 1'b1;
        reseted_next      = ns_index;
      end
    end

    case (state)
      IDLE: begin
        if (int_request) begin
          state_next   = PENDING;
          int_out_next = 1'b1;
        end
      end
      PENDING: begin
        if (inta_fall) begin
          state_next    = ACK1;
          freezing_next = 1'b1;
          ack_next      = 1'b1;
          int_out_next  = 1'b0;
          if (int_request) begin
            idx_next             = serviced_index;
            spurious_next        = 1'b0;
            isr_set[serviced_index] = 1'b1;
            irr_clear_next       = 1'b1;
            irr_clear_index_next = serviced_index;
          end else begin
            idx_next      = SPURIOUS_IDX;
            spurious_next = 1'b1;
          end
        end
      end
      ACK1: begin
        if (inta_rise) state_next = WAIT2;
      end
      WAIT2: begin
        if (inta_fall) begin
          state_next    = ACK2;
          data_out_next = {vector_base, idx};
          den_next      = 1'b1;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          state_next    = IDLE;
          den_next      = 1'b0;
          freezing_next = 1'b0;
          if (aeoi_en && !spurious) begin
            isr_clr[idx] = 1'b1;
            reseted_next = idx;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A set in the same cycle as a clear of the same bit wins.
    isr_next = (isr_reg & ~isr_clr) | isr_set;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= IDLE;
      inta_prev         <= 1'b1;
      idx               <= '0;
      spurious          <= 1'b0;
      int_out           <= 1'b0;
      freezing          <= 1'b0;
      int_request_ack   <= 1'b0;
      irr_clear         <= 1'b0;
      irr_clear_index   <= '0;
      isr_reg           <= '0;
      reseted_isr_index <= '0;
      data_out          <= '0;
      data_out_en       <= 1'b0;
    end else begin
      state             <= state_next;
      inta_prev         <= inta_s;
      idx               <= idx_next;
      spurious          <= spurious_next;
      int_out           <= int_out_next;
      freezing          <= freezing_next;
      int_request_ack   <= ack_next;
      irr_clear         <= irr_clear_next;
      irr_clear_index   <= irr_clear_index_next;
      isr_reg           <= isr_next;
      reseted_isr_index <= reseted_next;
      data_out          <= data_out_next;
      data_out_en       <= den_next;
    end
  end

endmodule
